memory_stage_hs: RTL and testbench
==================================

# memory_stage_hs

Parametrised successor to the pipeline memory stage; it sits between execution and writeback. It resolves branches, issues loads and stores over a request/grant/rvalid data bus that may insert wait states, and stalls execution while an access is outstanding. Results and load data go to writeback with a valid strobe. A wait-state timeout can abort a hung access.

## Interface
- XLEN, 32: datapath width; word address width is XLEN-2.
- TIMEOUT_CYC, 255: maximum cycles spent in REQ+WAIT before abort; 0 disables the timeout.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- ex_valid  in  1  execution presents an instruction.
- ex_ready  out  1  stage can accept; equals (state==IDLE).
- ex_branch_addr, ex_result, ex_rs2_data  in  XLEN  branch target, ALU result/address, store data.
- ex_funct3  in  3 / ex_rd  in  5  funct3 and destination register.
- ex_equal, ex_lesser, ex_greater  in  1  comparison flags.
- ex_read, ex_write, ex_branch, ex_u_branch, ex_write_reg, ex_select  in  1  control bits.
- wb_valid  out  1  one-cycle strobe: an instruction completes.
- wb_result, wb_rdata  out  XLEN  ALU result; raw load word.
- wb_funct3  out  3 / wb_rd  out  5 / wb_write_reg, wb_select  out  1  forwarded to writeback.
- load_next_pc  out  1 / next_pc  out  XLEN  branch-taken pulse and target.
- mem_req  out  1 / mem_we  out  1 / mem_addr  out  XLEN-2 / mem_wdata  out  XLEN / mem_be  out  XLEN/8  bus request.
- mem_gnt  in  1 / mem_rvalid  in  1 / mem_rdata  in  XLEN  bus response.
- bus_err  out  1 / misalign_err  out  1  one-cycle error pulses.

## Operation
- Accept = ex_valid & ex_ready. Non-memory instruction: wb_* registered, wb_valid=1 next cycle.
- Branch resolve on funct3: 000 equal; 001 !equal; 100/110 lesser; 101/111 !lesser. load_next_pc <= (resolve&ex_branch)|ex_u_branch on accept; next_pc <= ex_branch_addr. Pulse lasts one cycle.
- Memory op (ex_read|ex_write): latch mem_addr=result[XLEN-1:2], mem_we, be, wdata; go to REQ.
- Lanes by funct3[1:0] and offset: byte -> be=1<<off, data replicated per byte; half -> be=0011 or 1100 by off[1], data replicated per half; word -> be all ones.
- FSM IDLE->REQ on memory accept. In REQ: mem_req=1, with addr/we/be/wdata stable until mem_gnt.
- Store completes at the gnt edge and goes to IDLE. Load goes to WAIT on gnt, or completes directly if mem_rvalid is high in the same cycle.
- In WAIT: complete on mem_rvalid and capture wb_rdata.
- Completion gives wb_valid=1 for one cycle.
- Timeout: a counter clears on entry to REQ and increments each REQ/WAIT cycle. On reaching TIMEOUT_CYC: mem_req drops, bus_err=1, wb_valid=1, wb_rdata=0, wb_write_reg=0, state returns to IDLE.
- A branch and a memory op in the same instruction are both performed.
- mem_rvalid seen in IDLE or REQ without gnt is ignored.

## Timing
- Reset: all outputs 0, state IDLE, ex_ready=1. Reset mid-access drops mem_req asynchronously. A later rvalid for the killed load is ignored.
- Latency: non-memory op 1 cycle. Store 1 + grant wait. Load 1 + grant wait + rvalid wait + 1.
- mem_* outputs are registered. ex_ready is combinational from state.
- Back-to-back non-memory instructions sustain one per cycle.

## Configuration
- MISALIGN_TRAP_EN defined: a half at offset 3, or a word at offset ≠ 0, issues no bus request. It produces misalign_err=1 and wb_valid=1 with wb_write_reg=0, one cycle after accept.
- Not defined: low address bits are ignored for lane selection beyond the rules above, and misalign_err is tied to 0.

## Structure
- Package mem_stage_pkg holds:
  - the state enum (IDLE, REQ, WAIT);
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - branch constants F3_BEQ through F3_BGEU.
- One sub-module, mem_byte_lane, computes be and replicated wdata from funct3, offset and store data. It is parameterised by XLEN.

## Test plan
- Reset, then non-memory op with result=0x1234, rd=5 -> next cycle wb_valid=1, wb_result=0x1234, wb_rd=5, ex_ready stays 1.
- BNE with equal=0, target 0x80 -> load_next_pc=1 for one cycle, next_pc=0x80. Same with equal=1 -> load_next_pc=0.
- SB at address 0x103, data 0xAB, gnt delayed 3 cycles -> mem_be=1000, mem_wdata=0xABABABAB held stable, ex_ready=0 until gnt, wb_valid one cycle after gnt.
- LW at 0x200 with gnt and rvalid in the same cycle, rdata=0xDEADBEEF -> wb_rdata=0xDEADBEEF and wb_valid the next cycle.
- LW with no rvalid and TIMEOUT_CYC=4 -> bus_err pulses after 4 cycles, wb_write_reg=0, ex_ready returns to 1.
- With MISALIGN_TRAP_EN, SW at 0x102 -> mem_req never asserted, misalign_err=1 one cycle after accept.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared state, funct3 encodings and decode helpers for memory_stage_hs
package mem_stage_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;
  localparam logic [2:0] F3_B = 3'b000, F3_H = 3'b001, F3_W = 3'b010, F3_BU = 3'b100, F3_HU = 3'b101;
  localparam logic [2:0] F3_BEQ = 3'b000, F3_BNE = 3'b001, F3_BLT = 3'b100, F3_BGE = 3'b101,
                         F3_BLTU = 3'b110, F3_BGEU = 3'b111;
  function automatic size_t lane_size(input logic [2:0] f3);
    return (f3 == F3_B || f3 == F3_BU) ? SZ_B : (f3 == F3_H || f3 == F3_HU) ? SZ_H : SZ_W;
  endfunction
  // Signed and unsigned compares share the lesser flag; execute picks the flavour.
  function automatic logic branch_taken(input logic [2:0] f3, input logic eq, input logic lt);
    return f3 == F3_BEQ ? eq : f3 == F3_BNE ? !eq :
           (f3 == F3_BLT || f3 == F3_BLTU) ? lt : (f3 == F3_BGE || f3 == F3_BGEU) ? !lt : 1'b0;
  endfunction
endpackage

// File: rtl/mem_byte_lane.sv
// mem_byte_lane: byte enables and lane-replicated store data from funct3 and address offset
module mem_byte_lane
  import mem_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]        funct3,
  input  logic [1:0]        off,
  input  logic [XLEN-1:0]   data,
  output logic [XLEN/8-1:0] be,
  output logic [XLEN-1:0]   wdata
);
  localparam int NB = XLEN / 8;
  size_t sz;
  always_comb begin
    sz = lane_size(funct3);
    be = sz == SZ_B ? NB'(1) << off : sz == SZ_H ? NB'(3) << {off[1], 1'b0} : '1;
    wdata = sz == SZ_B ? {NB{data[7:0]}} : sz == SZ_H ? {(XLEN/16){data[15:0]}} : data;
  end
endmodule

// File: rtl/memory_stage_hs.sv
// memory_stage_hs: branch resolve plus req/gnt/rvalid load-store stage with wait-state timeout.
// Define MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of issuing them.
module memory_stage_hs
  import mem_stage_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [XLEN-1:0]   ex_branch_addr,
  input  logic [XLEN-1:0]   ex_result,
  input  logic [XLEN-1:0]   ex_rs2_data,
  input  logic [2:0]        ex_funct3,
  input  logic [4:0]        ex_rd,
  input  logic              ex_equal,
  input  logic              ex_lesser,
  input  logic              ex_greater,
  input  logic              ex_read,
  input  logic              ex_write,
  input  logic              ex_branch,
  input  logic              ex_u_branch,
  input  logic              ex_write_reg,
  input  logic              ex_select,
  output logic              wb_valid,
  output logic [XLEN-1:0]   wb_result,
  output logic [XLEN-1:0]   wb_rdata,
  output logic [2:0]        wb_funct3,
  output logic [4:0]        wb_rd,
  output logic              wb_write_reg,
  output logic              wb_select,
  output logic              load_next_pc,
  output logic [XLEN-1:0]   next_pc,
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN-3:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_be,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              bus_err,
  output logic              misalign_err
);
  state_t state, state_n;
  logic accept, is_mem, mis, go_bus, timeout, st_done, ld_done, done, abort;
  logic [31:0] cnt;
  logic [XLEN/8-1:0] be_n;
  logic [XLEN-1:0] wdata_n;
  logic unused_greater;
  assign unused_greater = ex_greater;
  mem_byte_lane #(.XLEN(XLEN)) u_lane (
    .funct3(ex_funct3),
    .off   (ex_result[1:0]),
    .data  (ex_rs2_data),
    .be    (be_n),
    .wdata (wdata_n)
  );
`ifdef MISALIGN_TRAP_EN
  assign mis = (lane_size(ex_funct3) == SZ_H && ex_result[1:0] == 2'd3) ||
               (lane_size(ex_funct3) == SZ_W && ex_result[1:0] != 2'd0);
`else
  assign mis = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state == IDLE ? (go_bus ? REQ : IDLE) :
              (done || abort) ? IDLE :
              (state == REQ && mem_gnt) ? WAIT : state;
  end
  // Completion wins over a timeout landing on the same edge.
  always_comb begin
    ex_ready = state == IDLE;
    accept = ex_valid && ex_ready;
    is_mem = ex_read || ex_write;
    go_bus = accept && is_mem && !mis;
    timeout = TIMEOUT_CYC != 0 && state != IDLE && cnt == 32'(TIMEOUT_CYC - 1);
    st_done = state == REQ && mem_gnt && mem_we;
    ld_done = mem_rvalid && ((state == REQ && mem_gnt && !mem_we) || state == WAIT);
    done = st_done || ld_done;
    abort = timeout && !done;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      wb_valid <= 1'b0;
      wb_result <= '0;
      wb_rdata <= '0;
      wb_funct3 <= '0;
      wb_rd <= '0;
      wb_write_reg <= 1'b0;
      wb_select <= 1'b0;
      load_next_pc <= 1'b0;
      next_pc <= '0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_be <= '0;
      bus_err <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      cnt <= state == IDLE ? '0 : cnt + 32'd1;
      wb_valid <= (accept && !go_bus) || done || abort;
      load_next_pc <= accept && ((branch_taken(ex_funct3, ex_equal, ex_lesser) && ex_branch) || ex_u_branch);
      bus_err <= abort;
      misalign_err <= accept && is_mem && mis;
      if (accept) begin
        next_pc <= ex_branch_addr;
        wb_result <= ex_result;
        wb_funct3 <= ex_funct3;
        wb_rd <= ex_rd;
        wb_select <= ex_select;
        wb_write_reg <= ex_write_reg && !(is_mem && mis);
      end
      if (ld_done) wb_rdata <= mem_rdata;
      if (abort) begin
        wb_rdata <= '0;
        wb_write_reg <= 1'b0;
      end
      if (go_bus) begin
        mem_req <= 1'b1;
        mem_we <= ex_write;
        mem_addr <= ex_result[XLEN-1:2];
        mem_be <= be_n;
        mem_wdata <= wdata_n;
      end else if (state == REQ && (mem_gnt || abort)) mem_req <= 1'b0;
    end
endmodule

// File: tb/tb_memory_stage_hs.sv
// tb_memory_stage_hs: scoreboard bench for memory_stage_hs (writeback checked by a negedge monitor)
module tb_memory_stage_hs;
  import mem_stage_pkg::*;
  localparam int XLEN = 32;
  localparam int TO = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic ex_valid, ex_ready, ex_equal, ex_lesser, ex_greater;
  logic ex_read, ex_write, ex_branch, ex_u_branch, ex_write_reg, ex_select;
  logic [31:0] ex_branch_addr, ex_result, ex_rs2_data;
  logic [2:0] ex_funct3, wb_funct3;
  logic [4:0] ex_rd, wb_rd;
  logic wb_valid, wb_write_reg, wb_select, load_next_pc;
  logic [31:0] wb_result, wb_rdata, next_pc, mem_wdata, mem_rdata;
  logic mem_req, mem_we, mem_gnt, mem_rvalid, bus_err, misalign_err;
  logic [29:0] mem_addr;
  logic [3:0] mem_be;
  always #5 clk = ~clk;

  memory_stage_hs #(.XLEN(XLEN), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_branch_addr(ex_branch_addr), .ex_result(ex_result), .ex_rs2_data(ex_rs2_data),
    .ex_funct3(ex_funct3), .ex_rd(ex_rd), .ex_equal(ex_equal), .ex_lesser(ex_lesser),
    .ex_greater(ex_greater), .ex_read(ex_read), .ex_write(ex_write), .ex_branch(ex_branch),
    .ex_u_branch(ex_u_branch), .ex_write_reg(ex_write_reg), .ex_select(ex_select),
    .wb_valid(wb_valid), .wb_result(wb_result), .wb_rdata(wb_rdata), .wb_funct3(wb_funct3),
    .wb_rd(wb_rd), .wb_write_reg(wb_write_reg), .wb_select(wb_select),
    .load_next_pc(load_next_pc), .next_pc(next_pc), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .bus_err(bus_err), .misalign_err(misalign_err)
  );

  typedef struct {
    logic [31:0] result;
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic        wreg;
    logic        berr;
    logic        merr;
    logic        ck_rd;
  } exp_t;
  exp_t sb[$];
  exp_t e_m;
  int n_tests = 0, n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [31:0] res, input logic [31:0] baddr, input logic [31:0] rs2,
                      input logic [2:0] f3, input logic [4:0] rd, input logic rd_op, input logic wr,
                      input logic br, input logic ub, input logic eq, input logic lt, input logic wreg);
    ex_valid = 1'b1; ex_result = res; ex_branch_addr = baddr; ex_rs2_data = rs2;
    ex_funct3 = f3; ex_rd = rd; ex_read = rd_op; ex_write = wr; ex_branch = br;
    ex_u_branch = ub; ex_equal = eq; ex_lesser = lt; ex_write_reg = wreg;
    if (!(rd_op || wr)) sb.push_back('{res, 32'h0, rd, wreg, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    ex_valid = 1'b0;
  endtask

  always @(negedge clk)
    if (!rst && wb_valid) begin
      if (sb.size() == 0) check("wb_spurious", 64'd1, 64'd0);
      else begin
        e_m = sb.pop_front();
        check("wb_result", wb_result, e_m.result);
        check("wb_rd", wb_rd, e_m.rd);
        check("wb_wreg", wb_write_reg, e_m.wreg);
        check("wb_berr", bus_err, e_m.berr);
        check("wb_merr", misalign_err, e_m.merr);
        if (e_m.ck_rd) check("wb_rdata", wb_rdata, e_m.rdata);
      end
    end

  logic [2:0] bf3 [8] = '{F3_BNE, F3_BNE, F3_BEQ, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU, F3_BEQ};
  logic       beq [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic       blt [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic       bub [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic       bex [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    ex_valid = 0; ex_branch_addr = 0; ex_result = 0; ex_rs2_data = 0; ex_funct3 = 0; ex_rd = 0;
    ex_equal = 0; ex_lesser = 0; ex_greater = 0; ex_read = 0; ex_write = 0; ex_branch = 0;
    ex_u_branch = 0; ex_write_reg = 0; ex_select = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    repeat (2) @(negedge clk);
    check("rst_ready", ex_ready, 1);
    check("rst_req", mem_req, 0);
    check("rst_wbv", wb_valid, 0);
    check("rst_lnpc", load_next_pc, 0);
    check("rst_berr", bus_err, 0);
    check("rst_merr", misalign_err, 0);
    rst = 1'b0;
    @(negedge clk);
    send(32'h1234, 0, 0, F3_W, 5'd5, 0, 0, 0, 0, 0, 0, 1);
    check("nm_ready", ex_ready, 1);
    check("nm_wbv", wb_valid, 1);
    for (int i = 0; i < 4; i++) begin
      send(32'h100 + i, 0, 0, F3_W, 5'(i + 1), 0, 0, 0, 0, 0, 0, 1);
      check("b2b_wbv", wb_valid, 1);
      check("b2b_ready", ex_ready, 1);
    end
    @(negedge clk);
    check("idle_wbv", wb_valid, 0);
    for (int i = 0; i < 8; i++) begin
      send(i, 32'h80 + 4 * i, 0, bf3[i], 5'd1, 0, 0, !bub[i], bub[i], beq[i], blt[i], 0);
      check("br_lnpc", load_next_pc, bex[i]);
      if (bex[i]) check("br_npc", next_pc, 32'h80 + 4 * i);
      @(negedge clk);
      check("br_pulse", load_next_pc, 0);
    end
    sb.push_back('{32'h103, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0});
    send(32'h103, 0, 32'h123456AB, F3_B, 5'd0, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      check("sb_req", mem_req, 1);
      check("sb_be", mem_be, 4'b1000);
      check("sb_wdata", mem_wdata, 32'hABABABAB);
      check("sb_addr", mem_addr, 30'h40);
      check("sb_we", mem_we, 1);
      check("sb_ready", ex_ready, 0);
      check("sb_wbv", wb_valid, 0);
      if (i == 3) mem_gnt = 1'b1;
      @(negedge clk);
    end
    mem_gnt = 1'b0;
    check("sb_done", wb_valid, 1);
    check("sb_ready1", ex_ready, 1);
    check("sb_req0", mem_req, 0);
    sb.push_back('{32'h102, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0});
    send(32'h102, 0, 32'h00005678, F3_H, 5'd0, 0, 1, 0, 0, 0, 0, 0);
    check("sh_be", mem_be, 4'b1100);
    check("sh_wdata", mem_wdata, 32'h56785678);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    check("sh_done", wb_valid, 1);
    sb.push_back('{32'h200, 32'hDEADBEEF, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1});
    send(32'h200, 0, 0, F3_W, 5'd7, 1, 0, 0, 0, 0, 0, 1);
    check("lw_req", mem_req, 1);
    check("lw_we", mem_we, 0);
    check("lw_addr", mem_addr, 30'h80);
    check("lw_be", mem_be, 4'hF);
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    check("lw_done", wb_valid, 1);
    mem_rvalid = 1'b1; mem_rdata = 32'h55;
    @(negedge clk);
    mem_rvalid = 1'b0;
    check("idle_rvalid", wb_valid, 0);
    sb.push_back('{32'h204, 32'hCAFEF00D, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1});
    send(32'h204, 0, 0, F3_W, 5'd8, 1, 0, 0, 0, 0, 0, 1);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    check("lww_req", mem_req, 0);
    check("lww_ready", ex_ready, 0);
    check("lww_wbv", wb_valid, 0);
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    mem_rvalid = 1'b0;
    check("lww_done", wb_valid, 1);
    sb.push_back('{32'h208, 32'h0, 5'd9, 1'b0, 1'b1, 1'b0, 1'b1});
    send(32'h208, 0, 0, F3_W, 5'd9, 1, 0, 0, 0, 0, 0, 1);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("to_berr0", bus_err, 0);
      check("to_ready0", ex_ready, 0);
      @(negedge clk);
    end
    check("to_berr", bus_err, 1);
    check("to_ready", ex_ready, 1);
    check("to_wbv", wb_valid, 1);
    @(negedge clk);
    check("to_pulse", bus_err, 0);
    sb.push_back('{32'h20C, 32'h0, 5'd10, 1'b0, 1'b1, 1'b0, 1'b1});
    send(32'h20C, 0, 0, F3_W, 5'd10, 1, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      check("tor_req", mem_req, 1);
      check("tor_berr0", bus_err, 0);
      @(negedge clk);
    end
    check("tor_req0", mem_req, 0);
    check("tor_berr", bus_err, 1);
    mem_rvalid = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b0;
    check("tor_late_rv", wb_valid, 0);
    send(32'h300, 0, 0, F3_W, 5'd11, 1, 0, 0, 0, 0, 0, 1);
    check("ra_req", mem_req, 1);
    #2 rst = 1'b1;
    #1;
    check("ra_req0", mem_req, 0);
    check("ra_ready", ex_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    mem_rvalid = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b0;
    check("ra_late_rv", wb_valid, 0);
`ifdef MISALIGN_TRAP_EN
    sb.push_back('{32'h102, 32'h0, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0});
    send(32'h102, 0, 32'h11223344, F3_W, 5'd3, 0, 1, 0, 0, 0, 0, 1);
    check("mis_err", misalign_err, 1);
    check("mis_req", mem_req, 0);
    check("mis_wbv", wb_valid, 1);
    check("mis_ready", ex_ready, 1);
    @(negedge clk);
    check("mis_pulse", misalign_err, 0);
    check("mis_req1", mem_req, 0);
    sb.push_back('{32'h103, 32'h0, 5'd4, 1'b0, 1'b0, 1'b1, 1'b0});
    send(32'h103, 0, 0, F3_H, 5'd4, 1, 0, 0, 0, 0, 0, 1);
    check("mish_err", misalign_err, 1);
    check("mish_req", mem_req, 0);
`else
    sb.push_back('{32'h102, 32'h0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0});
    send(32'h102, 0, 32'h11223344, F3_W, 5'd3, 0, 1, 0, 0, 0, 0, 0);
    check("sw_req", mem_req, 1);
    check("sw_be", mem_be, 4'hF);
    check("sw_addr", mem_addr, 30'h40);
    check("sw_merr", misalign_err, 0);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    check("sw_done", wb_valid, 1);
`endif
    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
